branch_pred_host_driver: RTL
============================

Name: branch_pred_host_driver

Overview:
- Host-side initiator for the branch predictor handshake. Accepts branch records (PC low byte plus actual outcome) into a small FIFO.
- For each record it drives inst_lowest_byte / direction_ground_truth / new_data_avail into the predictor, then captures the prediction and waits for training to complete.
- Reports per-branch results and running hit/mispredict statistics.
- Sits between a trace source (test harness or SoC bus) and the predictor's ui_in/uio_in pins.

Parameters:
- FIFO_DEPTH, 4, record FIFO entries; power of two, >= 2
- CNT_W, 16, width of statistics counters
- TIMEOUT_CYCLES, 255, watchdog limit in cycles; used only with the optional feature

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  branch record offered
- in_ready  out  1  FIFO can accept a record
- in_pc_byte  in  8  branch instruction address, lowest byte
- in_taken  in  1  actual branch direction (1 = taken)
- inst_lowest_byte  out  8  to predictor ui_in
- new_data_avail  out  1  to predictor uio_in[0]
- direction_ground_truth  out  1  to predictor uio_in[1]
- pred_ready  in  1  from predictor uo_out[0]
- prediction  in  1  from predictor uo_out[1]
- training_done  in  1  from predictor uo_out[2]
- mem_reset_done  in  1  from predictor uo_out[3]
- res_valid  out  1  one-cycle pulse, result fields valid
- res_prediction  out  1  captured prediction
- res_correct  out  1  prediction == ground truth
- total_cnt  out  CNT_W  branches completed
- mispred_cnt  out  CNT_W  mispredicted branches
- busy  out  1  FSM not in IDLE, or FIFO non-empty
- timeout_err  out  1  sticky watchdog flag

Behaviour:
- Clock and reset: single clock; rst is synchronous and active-high.
- Reset values:
  - All outputs 0, except in_ready = 1.
  - FIFO emptied; FSM enters WAIT_MEM.
  - Applies identically mid-transaction: new_data_avail drops on the next edge and the in-flight record is lost without being counted.
- FIFO:
  - Push when in_valid && in_ready.
  - in_ready = !full, evaluated from the registered state; a push is refused while full even if a pop happens in the same cycle.
  - Pointers wrap modulo FIFO_DEPTH.
  - Simultaneous push and pop while non-full: both occur and the count is unchanged.
- FSM states:
  - WAIT_MEM: hold outputs low. Go to IDLE on the first cycle mem_reset_done == 1.
  - IDLE: if the FIFO is non-empty, latch the head into inst_lowest_byte and direction_ground_truth, pop, and go to SETUP. new_data_avail stays 0.
  - SETUP: one cycle so data is stable before the edge. Set new_data_avail = 1, go to WAIT_PRED.
  - WAIT_PRED: hold new_data_avail = 1. When pred_ready == 1, capture prediction into res_prediction and go to WAIT_TRAIN. If pred_ready and training_done are both 1 in the same cycle, capture and complete in that one cycle, i.e. behave as WAIT_TRAIN completion.
  - WAIT_TRAIN: when training_done == 1:
    - Pulse res_valid for exactly one cycle.
    - res_correct = (res_prediction == direction_ground_truth).
    - Increment total_cnt; increment mispred_cnt if incorrect.
    - Drop new_data_avail; go to RELEASE.
  - RELEASE: new_data_avail = 0. Go to IDLE once pred_ready == 0 && training_done == 0 (minimum one cycle in RELEASE).
- Latency and outputs:
  - Minimum IDLE-to-new_data_avail rise is 2 cycles.
  - res_* hold their values until the next res_valid.
  - inst_lowest_byte and direction_ground_truth hold from the IDLE latch until the next latch.
- Counters: saturate at all-ones and never wrap; mispred_cnt <= total_cnt always.

Optional Feature:
- Macro: BRANCH_PRED_HOST_TIMEOUT_EN.
- With the macro:
  - A watchdog counter clears on entry to WAIT_PRED and counts cycles spent in WAIT_PRED, WAIT_TRAIN and RELEASE.
  - On reaching TIMEOUT_CYCLES: set timeout_err (sticky until rst), drop new_data_avail, return to IDLE.
  - The record is discarded: no res_valid, no counter update.
- Without the macro: no watchdog logic; timeout_err is tied to 0; the FSM waits indefinitely.

Test Plan:
- Reset then mem_reset_done held 0 for 10 cycles -> new_data_avail stays 0 and the FSM stays in WAIT_MEM. Raise mem_reset_done -> a queued record issues: new_data_avail rises 2 cycles after IDLE with inst_lowest_byte = 0x3C already stable.
- Record (0xA5, taken=1); model returns pred_ready 3 cycles later with prediction = 1, then training_done 2 cycles later -> one res_valid pulse with res_correct = 1, total_cnt = 1, mispred_cnt = 0, new_data_avail low the cycle after training_done.
- Record (0x10, taken=0) with prediction = 1 -> res_correct = 0, mispred_cnt increments by 1.
- Push 6 records back-to-back with predictor stalled, FIFO_DEPTH = 4 -> in_ready deasserts after 5 accepted (4 in FIFO plus 1 issued); the 6th is accepted only after the next pop; all 6 complete in push order.
- Assert rst during WAIT_TRAIN -> next cycle all outputs 0, counters 0, FIFO empty, FSM in WAIT_MEM.
- With BRANCH_PRED_HOST_TIMEOUT_EN, TIMEOUT_CYCLES = 20, pred_ready never asserted -> timeout_err = 1 at cycle 20 after WAIT_PRED entry, no res_valid, total_cnt unchanged, next record issues normally.

Source files
------------

// File: rtl/branch_pred_host_driver_if.sv
// Handshake bundle between the host driver, its trace source and the branch
// predictor pins. The host driver uses the master view. The trace source and
// the predictor (or a testbench standing in for both) use the slave view.
interface branch_pred_host_driver_if;
    // Trace-source side: branch records offered to the record FIFO
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_pc_byte;
    logic       in_taken;

    // Predictor side: ui_in / uio_in outputs and uo_out inputs
    logic [7:0] inst_lowest_byte;
    logic       new_data_avail;
    logic       direction_ground_truth;
    logic       pred_ready;
    logic       prediction;
    logic       training_done;
    logic       mem_reset_done;

    modport master (
        input  in_valid, in_pc_byte, in_taken,
        input  pred_ready, prediction, training_done, mem_reset_done,
        output in_ready, inst_lowest_byte, new_data_avail, direction_ground_truth
    );

    modport slave (
        output in_valid, in_pc_byte, in_taken,
        output pred_ready, prediction, training_done, mem_reset_done,
        input  in_ready, inst_lowest_byte, new_data_avail, direction_ground_truth
    );
endinterface

// File: rtl/branch_pred_host_driver.sv
// Host-side initiator for the branch predictor handshake. Branch records are
// queued in a small FIFO, issued one at a time to the predictor, and the
// returned prediction is scored against the actual outcome.
// Optional watchdog: define BRANCH_PRED_HOST_TIMEOUT_EN to abort a record that
// stalls for TIMEOUT_CYCLES cycles and raise the sticky timeout_err flag.
module branch_pred_host_driver #(
    parameter int FIFO_DEPTH     = 4,
    parameter int CNT_W          = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                        clk,
    input  logic                        rst,
    branch_pred_host_driver_if.master   bus,
    output logic                        res_valid,
    output logic                        res_prediction,
    output logic                        res_correct,
    output logic [CNT_W-1:0]            total_cnt,
    output logic [CNT_W-1:0]            mispred_cnt,
    output logic                        busy,
    output logic                        timeout_err
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);

    // Reject configurations the pointer arithmetic cannot support
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("branch_pred_host_driver: FIFO_DEPTH must be a power of two >= 2");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("branch_pred_host_driver: TIMEOUT_CYCLES must be >= 1");
    end

    typedef enum logic [2:0] {
        S_WAIT_MEM,
        S_IDLE,
        S_SETUP,
        S_WAIT_PRED,
        S_WAIT_TRAIN,
        S_RELEASE
    } state_e;

    typedef struct packed {
        logic [7:0] pc;
        logic       taken;
    } rec_t;

    // ------------------------------------------------------------------
    // Record FIFO
    // ------------------------------------------------------------------
    rec_t              fifo_mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [FCNT_W-1:0] fifo_cnt_q, fifo_cnt_d;
    logic              fifo_full, fifo_empty;
    logic              push, pop;
    rec_t              head;

    assign fifo_full  = (fifo_cnt_q == FCNT_W'(FIFO_DEPTH));
    assign fifo_empty = (fifo_cnt_q == '0);
    // Acceptance looks only at registered occupancy, so a same-cycle pop never frees a slot early
    assign push       = bus.in_valid && !fifo_full;
    assign head       = fifo_mem_q[rd_ptr_q];

    // Pointer and occupancy update; pointers wrap naturally since depth is a power of two
    always_comb begin
        wr_ptr_d   = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        fifo_cnt_d = fifo_cnt_q;
        case ({push, pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + FCNT_W'(1);
            2'b01:   fifo_cnt_d = fifo_cnt_q - FCNT_W'(1);
            default: fifo_cnt_d = fifo_cnt_q;
        endcase
    end

    // Record storage write port
    // NOTE: the storage array has no reset; fifo_cnt_q alone decides which entries are meaningful.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= '{pc: bus.in_pc_byte, taken: bus.in_taken};
        end
    end

    // ------------------------------------------------------------------
    // Handshake FSM and result datapath
    // ------------------------------------------------------------------
    state_e           state_q, state_d;
    logic [7:0]       inst_q, inst_d;
    logic             dir_q, dir_d;
    logic             nda_q, nda_d;
    logic             res_valid_q, res_valid_d;
    logic             res_pred_q, res_pred_d;
    logic             res_correct_q, res_correct_d;
    logic [CNT_W-1:0] total_q, total_d;
    logic [CNT_W-1:0] mispred_q, mispred_d;
    logic             finish;
    logic             finish_pred;

`ifdef BRANCH_PRED_HOST_TIMEOUT_EN
    localparam int WDOG_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WDOG_W-1:0] wdog_q, wdog_d;
    logic              timeout_err_q, timeout_err_d;
`endif

    // Next-state, issue, capture and scoring logic
    // NOTE: every signal written here gets its default first, so no path leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_d       = state_q;
        inst_d        = inst_q;
        dir_d         = dir_q;
        nda_d         = nda_q;
        res_valid_d   = 1'b0;
        res_pred_d    = res_pred_q;
        res_correct_d = res_correct_q;
        total_d       = total_q;
        mispred_d     = mispred_q;
        pop           = 1'b0;
        finish        = 1'b0;
        finish_pred   = res_pred_q;

        case (state_q)
            S_WAIT_MEM: begin
                nda_d = 1'b0;
                if (bus.mem_reset_done) state_d = S_IDLE;
            end
            S_IDLE: begin
                nda_d = 1'b0;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    inst_d  = head.pc;
                    dir_d   = head.taken;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                // Data has been stable for a full cycle; raise the strobe
                nda_d   = 1'b1;
                state_d = S_WAIT_PRED;
            end
            S_WAIT_PRED: begin
                if (bus.pred_ready) begin
                    res_pred_d = bus.prediction;
                    if (bus.training_done) begin
                        finish      = 1'b1;
                        finish_pred = bus.prediction;
                    end else begin
                        state_d = S_WAIT_TRAIN;
                    end
                end
            end
            S_WAIT_TRAIN: begin
                if (bus.training_done) begin
                    finish      = 1'b1;
                    finish_pred = res_pred_q;
                end
            end
            S_RELEASE: begin
                nda_d = 1'b0;
                if (!bus.pred_ready && !bus.training_done) state_d = S_IDLE;
            end
            default: state_d = S_WAIT_MEM;
        endcase

        // Training finished: publish the result and update saturating statistics
        if (finish) begin
            res_valid_d   = 1'b1;
            res_correct_d = (finish_pred == dir_q);
            total_d       = (&total_q) ? total_q : total_q + CNT_W'(1);
            if (finish_pred != dir_q && !(&mispred_q)) begin
                mispred_d = mispred_q + CNT_W'(1);
            end
            nda_d   = 1'b0;
            state_d = S_RELEASE;
        end

`ifdef BRANCH_PRED_HOST_TIMEOUT_EN
        // Watchdog: an expired record is dropped without touching results or counters
        wdog_d        = wdog_q;
        timeout_err_d = timeout_err_q;
        if (state_q == S_SETUP) begin
            wdog_d = '0;
        end else if (state_q inside {S_WAIT_PRED, S_WAIT_TRAIN, S_RELEASE}) begin
            if (wdog_q == WDOG_W'(TIMEOUT_CYCLES - 1)) begin
                timeout_err_d = 1'b1;
                nda_d         = 1'b0;
                state_d       = S_IDLE;
                res_valid_d   = 1'b0;
                res_pred_d    = res_pred_q;
                res_correct_d = res_correct_q;
                total_d       = total_q;
                mispred_d     = mispred_q;
            end else begin
                wdog_d = wdog_q + WDOG_W'(1);
            end
        end
`endif
    end

    // State and datapath registers with synchronous reset
    // NOTE: sequential state uses non-blocking assignment so all flops update together from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_WAIT_MEM;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            fifo_cnt_q    <= '0;
            inst_q        <= '0;
            dir_q         <= 1'b0;
            nda_q         <= 1'b0;
            res_valid_q   <= 1'b0;
            res_pred_q    <= 1'b0;
            res_correct_q <= 1'b0;
            total_q       <= '0;
            mispred_q     <= '0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            fifo_cnt_q    <= fifo_cnt_d;
            inst_q        <= inst_d;
            dir_q         <= dir_d;
            nda_q         <= nda_d;
            res_valid_q   <= res_valid_d;
            res_pred_q    <= res_pred_d;
            res_correct_q <= res_correct_d;
            total_q       <= total_d;
            mispred_q     <= mispred_d;
        end
    end

`ifdef BRANCH_PRED_HOST_TIMEOUT_EN
    // Watchdog counter and sticky error flag
    always_ff @(posedge clk) begin
        if (rst) begin
            wdog_q        <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            wdog_q        <= wdog_d;
            timeout_err_q <= timeout_err_d;
        end
    end
    assign timeout_err = timeout_err_q;
`else
    assign timeout_err = 1'b0;
`endif

    // Output mapping; waiting for predictor memory init is not counted as work
    assign bus.in_ready               = !fifo_full;
    assign bus.inst_lowest_byte       = inst_q;
    assign bus.direction_ground_truth = dir_q;
    assign bus.new_data_avail         = nda_q;
    assign res_valid                  = res_valid_q;
    assign res_prediction             = res_pred_q;
    assign res_correct                = res_correct_q;
    assign total_cnt                  = total_q;
    assign mispred_cnt                = mispred_q;
    assign busy                       = (state_q != S_IDLE && state_q != S_WAIT_MEM) || !fifo_empty;

endmodule
